// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 window generator with two line buffers for the Sobel stage
module sobel_window_gen #(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 256,
    parameter int CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [CNT_W-1:0]   width_i,
    input  logic [CNT_W-1:0]   height_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    input  logic [PIX_W-1:0]   pix_data_i,
    output logic               win_valid_o,
    input  logic               win_ready_i,
    output logic [9*PIX_W-1:0] win_data_o,
    output logic [CNT_W-1:0]   win_x_o,
    output logic [CNT_W-1:0]   win_y_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               cfg_err_o
);
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   w_q, h_q, x_q, y_q;
    logic [PIX_W-1:0]   lb0 [MAX_WIDTH];
    logic [PIX_W-1:0]   lb1 [MAX_WIDTH];
    // Columns packed {bottom, middle, top}; c1_q is the older of the two held columns.
    logic [3*PIX_W-1:0] c1_q, c2_q, col_new;
    logic [PIX_W-1:0]   rd_a, rd_b;
    logic               win_valid_q, frame_done_q, cfg_err_q;
    logic [9*PIX_W-1:0] win_data_q;
    logic [CNT_W-1:0]   win_x_q, win_y_q;
    logic               cfg_ok, start_ok, pix_accept, last_px, win_hs, win_load, x_last;

    assign rd_a    = lb0[x_q[AW-1:0]];
    assign rd_b    = lb1[x_q[AW-1:0]];
    assign col_new = {pix_data_i, rd_b, rd_a};

    assign cfg_ok     = (width_i >= CNT_W'(3)) && (width_i <= CNT_W'(MAX_WIDTH)) &&
                        (height_i >= CNT_W'(3));
    assign start_ok   = (state_q == S_IDLE) && start_i && cfg_ok;
    assign pix_ready_o = (state_q == S_RUN) && (!win_valid_q || win_ready_i);
    assign pix_accept = pix_valid_i && pix_ready_o;
    assign x_last     = (x_q == w_q - CNT_W'(1));
    assign last_px    = x_last && (y_q == h_q - CNT_W'(1));
    assign win_hs     = win_valid_q && win_ready_i;
    assign win_load   = pix_accept && (x_q >= CNT_W'(2)) && (y_q >= CNT_W'(2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (pix_accept && last_px) state_d = S_DRAIN;
            S_DRAIN: if (win_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == S_DRAIN) && win_hs && !clear_i;
            cfg_err_q    <= (state_q == S_IDLE) && start_i && !cfg_ok && !clear_i;
            if (clear_i) begin
                x_q         <= '0;
                y_q         <= '0;
                win_valid_q <= 1'b0;
            end else if (start_ok) begin
                w_q <= width_i;
                h_q <= height_i;
                x_q <= '0;
                y_q <= '0;
            end else begin
                if (pix_accept) begin
                    c1_q <= c2_q;
                    c2_q <= col_new;
                    if (x_last) begin
                        x_q <= '0;
                        y_q <= y_q + CNT_W'(1);
                    end else begin
                        x_q <= x_q + CNT_W'(1);
                    end
                end
                // A fresh window overwrites the one handshaking this cycle, keeping 1 px/clk.
                if (win_load) begin
                    win_valid_q <= 1'b1;
                    win_data_q  <= {pix_data_i, c2_q[3*PIX_W-1 -: PIX_W], c1_q[3*PIX_W-1 -: PIX_W],
                                    rd_b,       c2_q[2*PIX_W-1 -: PIX_W], c1_q[2*PIX_W-1 -: PIX_W],
                                    rd_a,       c2_q[PIX_W-1:0],          c1_q[PIX_W-1:0]};
                    win_x_q     <= x_q - CNT_W'(1);
                    win_y_q     <= y_q - CNT_W'(1);
                end else if (win_hs) begin
                    win_valid_q <= 1'b0;
                end
            end
        end
    end

    // Line buffers carry no reset; rows 0 and 1 of every frame rewrite them before use.
    always_ff @(posedge clk_i) begin
        if (pix_accept) begin
            lb0[x_q[AW-1:0]] <= rd_b;
            lb1[x_q[AW-1:0]] <= pix_data_i;
        end
    end

    assign win_valid_o  = win_valid_q;
    assign win_data_o   = win_data_q;
    assign win_x_o      = win_x_q;
    assign win_y_o      = win_y_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done_q;
    assign cfg_err_o    = cfg_err_q;
endmodule
